// File: rtl/indication_portal_mux.sv
// indication_portal_mux: multi-channel indication output portal.
// Each producer method feeds its own circular FIFO; the host reads one
// channel at a time through a shared read port, and gets a registered
// interrupt plus the lowest-index non-empty channel for servicing.

// One channel: circular buffer, occupancy count and sticky overflow flag.
module indication_chan_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq_en,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  enq_rdy,
    input  logic                  deq_en,
    output logic [DATA_WIDTH-1:0] first,
    output logic                  not_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W-1:0]      wptr;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;
    logic                  do_enq;
    logic                  do_deq;

    // Readiness comes from pre-edge state, so a full channel refuses an
    // enqueue even when a dequeue frees a slot in the same cycle.
    assign enq_rdy   = (cnt != CNT_W'(DEPTH));
    assign not_empty = (cnt != '0);
    assign do_enq    = enq_en & enq_rdy;
    assign do_deq    = deq_en & not_empty;
    assign first     = mem[rptr];
    assign count     = cnt;
    assign overflow  = ovf;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_enq) wptr <= wptr + PTR_W'(1);
            if (do_deq) rptr <= rptr + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wptr] <= enq_data;
    end

    // Sticky overflow: a refused enqueue sets it and wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= (enq_en & ~enq_rdy) | (ovf & ~overflow_clr);
    end
endmodule

module indication_portal_mux #(
    parameter int NUM_CHAN   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_CHAN-1:0]            ind_enq_en,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] ind_enq_data,
    output logic [NUM_CHAN-1:0]            ind_enq_rdy,
    input  logic [CHAN_W-1:0]              rd_chan,
    output logic                           rd_not_empty,
    output logic [DATA_WIDTH-1:0]          rd_first,
    output logic [CNT_W-1:0]               rd_count,
    input  logic                           rd_deq_en,
    output logic                           rd_deq_rdy,
    input  logic                           intr_en_wr,
    input  logic                           intr_en_data,
    output logic                           intr_status,
    output logic [31:0]                    intr_channel,
    output logic [NUM_CHAN-1:0]            overflow,
    input  logic [NUM_CHAN-1:0]            overflow_clr
);
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] first_vec;
    logic [NUM_CHAN-1:0][CNT_W-1:0]      count_vec;
    logic [NUM_CHAN-1:0]                 ne_vec;
    logic [NUM_CHAN-1:0]                 deq_vec;
    logic                                intr_en;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        // Out-of-range rd_chan matches no channel, so its deq is dropped.
        assign deq_vec[i] = rd_deq_en && (rd_chan == CHAN_W'(i));

        indication_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk          (CLK),
            .rst_n        (RST_N),
            .enq_en       (ind_enq_en[i]),
            .enq_data     (ind_enq_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .enq_rdy      (ind_enq_rdy[i]),
            .deq_en       (deq_vec[i]),
            .first        (first_vec[i]),
            .not_empty    (ne_vec[i]),
            .count        (count_vec[i]),
            .overflow     (overflow[i]),
            .overflow_clr (overflow_clr[i])
        );
    end

    // Host read mux; an unselected (out-of-range) channel reads as zeros.
    always_comb begin
        rd_not_empty = 1'b0;
        rd_count     = '0;
        rd_first     = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (rd_chan == CHAN_W'(i)) begin
                rd_not_empty = ne_vec[i];
                rd_count     = count_vec[i];
                rd_first     = first_vec[i];
            end
        end
    end

    assign rd_deq_rdy = rd_not_empty;

    // Lowest non-empty channel wins; all ones when nothing is pending.
    always_comb begin
        intr_channel = '1;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (ne_vec[i]) intr_channel = 32'(i);
        end
    end

    // Interrupt enable register and registered request (one cycle behind state).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_en     <= 1'b0;
            intr_status <= 1'b0;
        end else begin
            intr_status <= intr_en & (|ne_vec);
            if (intr_en_wr) intr_en <= intr_en_data;
        end
    end
endmodule

// File: tb/tb_indication_portal_mux.sv
// Bench for indication_portal_mux: directed scenarios then random traffic,
// all checked against a queue-per-channel reference model.
module tb_indication_portal_mux;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int D  = 8;
    localparam int CW = 2;
    localparam int NW = 4;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [NC-1:0]   ind_enq_en;
    logic [NC*DW-1:0] ind_enq_data;
    logic [NC-1:0]   ind_enq_rdy;
    logic [CW-1:0]   rd_chan;
    logic            rd_not_empty;
    logic [DW-1:0]   rd_first;
    logic [NW-1:0]   rd_count;
    logic            rd_deq_en;
    logic            rd_deq_rdy;
    logic            intr_en_wr;
    logic            intr_en_data;
    logic            intr_status;
    logic [31:0]     intr_channel;
    logic [NC-1:0]   overflow;
    logic [NC-1:0]   overflow_clr;

    indication_portal_mux #(.NUM_CHAN(NC), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ind_enq_en(ind_enq_en), .ind_enq_data(ind_enq_data), .ind_enq_rdy(ind_enq_rdy),
        .rd_chan(rd_chan), .rd_not_empty(rd_not_empty), .rd_first(rd_first),
        .rd_count(rd_count), .rd_deq_en(rd_deq_en), .rd_deq_rdy(rd_deq_rdy),
        .intr_en_wr(intr_en_wr), .intr_en_data(intr_en_data),
        .intr_status(intr_status), .intr_channel(intr_channel),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mq [NC][$];
    logic [NC-1:0] m_ovf;
    logic          m_ien;
    logic          m_istat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) mq[i].delete();
        m_ovf   = '0;
        m_ien   = 1'b0;
        m_istat = 1'b0;
    endtask

    task automatic idle();
        ind_enq_en   = '0;
        ind_enq_data = '0;
        rd_deq_en    = 1'b0;
        intr_en_wr   = 1'b0;
        intr_en_data = 1'b0;
        overflow_clr = '0;
    endtask

    task automatic put(input int ch, input logic [DW-1:0] d);
        ind_enq_en[ch]           = 1'b1;
        ind_enq_data[ch*DW +: DW] = d;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_all();
        logic [NC-1:0] rdy;
        logic [31:0]   ich;
        int            sel;
        sel = int'(rd_chan);
        ich = 32'hFFFF_FFFF;
        for (int i = 0; i < NC; i++) rdy[i] = (mq[i].size() != D);
        for (int i = NC - 1; i >= 0; i--) if (mq[i].size() != 0) ich = i;
        chk("enq_rdy", 32'(ind_enq_rdy), 32'(rdy));
        chk("rd_not_empty", 32'(rd_not_empty), 32'(mq[sel].size() != 0));
        chk("rd_deq_rdy", 32'(rd_deq_rdy), 32'(mq[sel].size() != 0));
        chk("rd_count", 32'(rd_count), 32'(mq[sel].size()));
        if (mq[sel].size() != 0) chk("rd_first", rd_first, mq[sel][0]);
        chk("intr_status", 32'(intr_status), 32'(m_istat));
        chk("intr_channel", intr_channel, ich);
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Apply the driven inputs for one clock and advance the model.
    task automatic tick();
        logic          any;
        logic [NC-1:0] dd, de;
        #1 check_all();
        @(posedge CLK);
        any = 1'b0;
        for (int i = 0; i < NC; i++) begin
            any  |= (mq[i].size() != 0);
            dd[i] = rd_deq_en && (int'(rd_chan) == i) && (mq[i].size() != 0);
            de[i] = ind_enq_en[i] && (mq[i].size() != D);
            if (ind_enq_en[i] && mq[i].size() == D) m_ovf[i] = 1'b1;
            else if (overflow_clr[i])               m_ovf[i] = 1'b0;
        end
        m_istat = m_ien & any;
        if (intr_en_wr) m_ien = intr_en_data;
        for (int i = 0; i < NC; i++) begin
            if (dd[i]) void'(mq[i].pop_front());
            if (de[i]) mq[i].push_back(ind_enq_data[i*DW +: DW]);
        end
        @(negedge CLK);
    endtask

    task automatic drain(input int ch);
        idle();
        rd_chan   = CW'(ch);
        rd_deq_en = 1'b1;
        while (mq[ch].size() != 0) tick();
        idle();
    endtask

    initial begin
        idle();
        rd_chan = '0;
        RST_N   = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_rdy", 32'(ind_enq_rdy), 32'hF);
        chk("reset_intr_channel", intr_channel, 32'hFFFF_FFFF);
        chk("reset_not_empty", 32'(rd_not_empty), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Single word on ch2 with interrupt enabled
        intr_en_wr = 1'b1; intr_en_data = 1'b1;
        tick();
        idle();
        rd_chan = 2'd2;
        put(2, 32'hA5A5_0001);
        tick();
        idle();
        #1;
        chk("t1_not_empty", 32'(rd_not_empty), 32'h1);
        chk("t1_first", rd_first, 32'hA5A5_0001);
        chk("t1_intr_channel", intr_channel, 32'h2);
        chk("t1_intr_status", 32'(intr_status), 32'h0);
        tick();
        #1 chk("t2_intr_status", 32'(intr_status), 32'h1);
        drain(2);

        // Fill ch1, overflow, drain in order, then wrap
        rd_chan = 2'd1;
        for (int k = 1; k <= 8; k++) begin idle(); put(1, k); tick(); end
        idle();
        #1 chk("full_rdy1", 32'(ind_enq_rdy[1]), 32'h0);
        put(1, 9);
        tick();
        idle();
        #1;
        chk("full_ovf1", 32'(overflow[1]), 32'h1);
        chk("full_count", 32'(rd_count), 32'h8);
        rd_deq_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1 chk("drain_order", rd_first, k);
            tick();
        end
        idle();
        overflow_clr[1] = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin idle(); put(1, 100 + r*10 + k); tick(); end
            idle();
            rd_deq_en = 1'b1;
            for (int k = 0; k < 5; k++) begin
                #1 chk("wrap_order", rd_first, 100 + r*10 + k);
                tick();
            end
        end
        idle();

        // Full ch0 with simultaneous enq+deq, then set-wins-over-clear
        rd_chan = 2'd0;
        for (int k = 0; k < 8; k++) begin idle(); put(0, 32'h0100 + k); tick(); end
        idle();
        put(0, 32'hDEAD); rd_deq_en = 1'b1;
        tick();
        idle();
        #1;
        chk("ed_ovf0", 32'(overflow[0]), 32'h1);
        chk("ed_count", 32'(rd_count), 32'h7);
        chk("ed_first", rd_first, 32'h0101);
        put(0, 32'h0108);
        tick();
        idle();
        put(0, 32'hBEEF); overflow_clr[0] = 1'b1;
        tick();
        idle();
        #1 chk("set_wins", 32'(overflow[0]), 32'h1);
        overflow_clr[0] = 1'b1;
        tick();
        idle();
        #1 chk("clr_ovf0", 32'(overflow[0]), 32'h0);
        drain(0);

        // Priority encoding of pending channels
        put(1, 32'h11); put(3, 32'h33);
        tick();
        idle();
        #1 chk("prio_1", intr_channel, 32'h1);
        drain(1);
        #1 chk("prio_3", intr_channel, 32'h3);
        drain(3);
        #1 chk("prio_none", intr_channel, 32'hFFFF_FFFF);
        tick();
        #1 chk("intr_drop", 32'(intr_status), 32'h0);

        // Asynchronous reset mid-burst
        rd_chan = 2'd0;
        for (int k = 0; k < 5; k++) begin idle(); put(0, 32'h500 + k); tick(); end
        idle();
        put(0, 32'h600);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_count", 32'(rd_count), 32'h0);
        chk("arst_not_empty", 32'(rd_not_empty), 32'h0);
        chk("arst_rdy", 32'(ind_enq_rdy), 32'hF);
        chk("arst_intr_channel", intr_channel, 32'hFFFF_FFFF);
        chk("arst_intr_status", 32'(intr_status), 32'h0);
        model_reset();
        idle();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        #1 chk("post_rst_count", 32'(rd_count), 32'h0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            rd_chan = CW'($urandom_range(0, NC - 1));
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 60 : 25)) put(i, $urandom);
            end
            rd_deq_en    = ($urandom_range(0, 99) < 45);
            overflow_clr = ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) begin
                intr_en_wr   = 1'b1;
                intr_en_data = 1'($urandom);
            end
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
